ray_column_buffer: RTL
======================

RAY_COLUMN_BUFFER -- requirements
Module: ray_column_buffer

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 320: number of columns (rays) per frame.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 240: screen height; lineHeight_out values range from 0 to SCREEN_HEIGHT.
REQ-003 SHALL have one clock and an asynchronous active-low reset: pixel_clk_in input 1, the only clock; rst_n_in input 1, asynchronous active-low reset.
REQ-004 SHALL have dda_out_tvalid, input, 1 bit: upstream column beat is valid.
REQ-005 SHALL have dda_out_tdata, input, 38 bits: [37:29] hcount_ray, [28:21] lineHeight, [20] wallType, [19:16] mapData, [15:0] wallX.
REQ-006 SHALL have dda_out_tlast, input, 1 bit: marks the final column of the frame.
REQ-007 SHALL have dda_out_tready, output, 1 bit: this block can accept a beat.
REQ-008 SHALL have frame_swap_in, input, 1 bit: single-cycle pulse from the renderer at vblank start.
REQ-009 SHALL have rd_hcount_in, input, 9 bits: column read address from the pixel pipeline.
REQ-010 SHALL have the following read outputs: rd_lineHeight_out 8 bits, rd_wallType_out 1 bit, rd_mapData_out 4 bits, rd_wallX_out 16 bits, and rd_valid_out 1 bit.
REQ-011 SHALL have frame_ready_out, output, 1 bit: back bank holds a complete frame.
REQ-012 SHALL have bank_sel_out, output, 1 bit: index of the bank currently being displayed (the front bank).
REQ-013 SHALL have column_err_out, output, 1 bit: sticky frame-integrity error (see Configuration).

Function
REQ-014 SHALL hold two banks of SCREEN_WIDTH x 29-bit column entries; the front bank is read, the back bank is written.
REQ-015 SHALL implement a two-state FSM with states FILL and FULL; dda_out_tready = 1 in FILL and 0 in FULL.
REQ-016 SHALL accept a beat only on a cycle where tvalid and tready are both high (accepted beat).
REQ-017 SHALL, on an accepted beat with hcount_ray < SCREEN_WIDTH, write tdata[28:0] to the back bank at address hcount_ray; a beat with hcount_ray >= SCREEN_WIDTH SHALL be accepted and discarded.
REQ-018 SHALL move from FILL to FULL on an accepted beat with tlast = 1; frame_ready_out is high exactly while in FULL.
REQ-019 SHALL, on frame_swap_in in state FULL, toggle bank_sel_out, set an internal front_valid flag, and return to FILL on the next cycle.
REQ-020 SHALL ignore frame_swap_in in state FILL; the front bank and bank_sel_out stay unchanged.
REQ-021 SHALL treat a cycle with both an accepted tlast beat and frame_swap_in as tlast only: go to FULL without swapping; the next swap pulse performs the swap.
REQ-022 SHALL apply a write and a swap in the same order they occur, so a column written on the cycle before a swap is visible after the swap.
REQ-023 SHALL have a read latency of 2 cycles: rd_* outputs reflect rd_hcount_in from two cycles earlier, read from the bank that was front at sample time.
REQ-024 SHALL drive rd_valid_out = 1 only when front_valid = 1 and the sampled rd_hcount_in < SCREEN_WIDTH; otherwise all rd_* data outputs SHALL be 0.
REQ-025 SHALL let columns that were not written in a frame keep their contents from the earlier use of that bank.

Reset
REQ-026 SHALL, on assertion of rst_n_in (low): state FILL, bank_sel_out 0, front_valid 0, frame_ready_out 0, column_err_out 0, all rd_* outputs 0, and the read pipeline cleared.
REQ-027 SHALL, when reset is asserted mid-frame, discard the partial frame; bank memory contents are not cleared.
REQ-028 SHALL drive dda_out_tready to 1 on the first clock edge after reset deassertion.

Configuration
REQ-029 SHALL support the macro COLUMN_CHECK_EN. When defined: a 9-bit per-frame beat counter counts accepted beats; column_err_out is set if a tlast beat arrives with count+1 != SCREEN_WIDTH, or if any beat has hcount_ray >= SCREEN_WIDTH. The error is sticky until reset, and the counter clears on each tlast beat.
REQ-030 SHALL, when COLUMN_CHECK_EN is not defined, tie column_err_out to 0 and include no counter logic.

Verification
REQ-031 SHALL cover normal frame: 320 beats hcount 0..319, tlast on 319, then swap pulse -> tready low after the last beat, frame_ready_out=1, then bank_sel_out=1, and rd_hcount_in=5 returns the beat-5 payload 2 cycles later with rd_valid_out=1.
REQ-032 SHALL cover backpressure: in FULL, tvalid held high for 50 cycles with no swap -> no beat accepted, back bank unchanged; after the swap, the next beat is accepted.
REQ-033 SHALL cover the collision: tlast accepted in the same cycle as frame_swap_in -> no swap, bank_sel_out unchanged, state FULL; the next swap pulse toggles the bank.
REQ-034 SHALL cover the pre-first-frame and out-of-range cases: reads before the first swap give rd_valid_out=0 and data 0; rd_hcount_in=320 gives rd_valid_out=0.
REQ-035 SHALL cover the error flag with COLUMN_CHECK_EN defined: 300 beats with tlast on the 300th -> column_err_out=1 and it stays set; with the macro undefined, column_err_out stays 0.
REQ-036 SHALL cover reset mid-frame: rst_n_in low after 100 beats -> all outputs at reset values; after release, tready=1 and a full frame completes normally.

Source files
------------

// File: rtl/ray_column_buffer_if.sv
// rtl/ray_column_buffer_if.sv - column beat stream between the DDA ray caster and the column buffer
//
// Purpose: carries one ray-cast column result per beat.
// Signals:
//   tvalid - producer has a column beat
//   tdata  - [37:29] hcount_ray, [28:21] lineHeight, [20] wallType, [19:16] mapData, [15:0] wallX
//   tlast  - final column of the frame
//   tready - consumer can accept a beat
// Modports: master (DDA side), slave (buffer side).

interface ray_column_buffer_if;
   logic        tvalid;
   logic [37:0] tdata;
   logic        tlast;
   logic        tready;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/ray_column_buffer.sv
// rtl/ray_column_buffer.sv - double-buffered per-column ray results between DDA and pixel pipeline
//
// Purpose: collects one frame of column entries into the back bank while the
// pixel pipeline reads the front bank; banks swap at vblank once a frame is complete.
// Optional feature macro: COLUMN_CHECK_EN (per-frame beat count / range check driving column_err_out).
// Ports:
//   pixel_clk_in      - only clock
//   rst_n_in          - asynchronous active-low reset
//   dda_out           - column beat stream (slave modport)
//   frame_swap_in     - single-cycle swap request at vblank start
//   rd_hcount_in      - column read address
//   rd_*_out          - column entry read 2 cycles after the address, rd_valid_out qualifies it
//   frame_ready_out   - back bank holds a complete frame
//   bank_sel_out      - index of the front (displayed) bank
//   column_err_out    - sticky frame-integrity error

module ray_column_buffer #(
   parameter int SCREEN_WIDTH  = 320,
   parameter int SCREEN_HEIGHT = 240
) (
   input  logic                 pixel_clk_in,
   input  logic                 rst_n_in,
   ray_column_buffer_if.slave   dda_out,
   input  logic                 frame_swap_in,
   input  logic [8:0]           rd_hcount_in,
   output logic [7:0]           rd_lineHeight_out,
   output logic                 rd_wallType_out,
   output logic [3:0]           rd_mapData_out,
   output logic [15:0]          rd_wallX_out,
   output logic                 rd_valid_out,
   output logic                 frame_ready_out,
   output logic                 bank_sel_out,
   output logic                 column_err_out
);

   // Column addresses are 9 bits and line heights 8 bits.
   if (SCREEN_WIDTH > 512 || SCREEN_HEIGHT > 255) begin : g_param_check
      $error("ray_column_buffer: SCREEN_WIDTH/SCREEN_HEIGHT exceed port widths");
   end

   localparam logic [9:0] WIDTH_L = 10'(SCREEN_WIDTH);

   typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

   state_t      state_q, state_d;
   logic        bank_sel_q;
   logic        front_valid_q;
   logic [28:0] mem_q [2][SCREEN_WIDTH];

   logic        s1_valid_q;
   logic [28:0] s1_word_q;
   logic        rd_valid_q;
   logic [28:0] rd_word_q;

   logic [8:0]  wr_addr;
   logic        accept;
   logic        wr_in_range;
   logic        rd_ok;
   logic        swap_fire;

   assign wr_addr     = dda_out.tdata[37:29];
   assign accept      = dda_out.tvalid && (state_q == FILL);
   assign wr_in_range = ({1'b0, wr_addr} < WIDTH_L);
   assign rd_ok       = front_valid_q && ({1'b0, rd_hcount_in} < WIDTH_L);
   // Swaps are only honoured in FULL, so a tlast beat colliding with a swap pulse never swaps.
   assign swap_fire   = (state_q == FULL) && frame_swap_in;

   // FSM: state register
   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state_q <= FILL;
      else           state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL: if (accept && dda_out.tlast) state_d = FULL;
         FULL: if (frame_swap_in)           state_d = FILL;
         default:                           state_d = FILL;
      endcase
   end

   // FSM: outputs
   always_comb begin
      dda_out.tready  = (state_q == FILL);
      frame_ready_out = (state_q == FULL);
   end

   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         bank_sel_q    <= 1'b0;
         front_valid_q <= 1'b0;
      end else if (swap_fire) begin
         bank_sel_q    <= ~bank_sel_q;
         front_valid_q <= 1'b1;
      end
   end

   // Bank storage is deliberately not reset: unwritten columns keep older contents.
   always_ff @(posedge pixel_clk_in) begin
      if (accept && wr_in_range) mem_q[~bank_sel_q][wr_addr] <= dda_out.tdata[28:0];
   end

   // Stage 1 reads the front bank at sample time, so a later swap cannot redirect an in-flight read.
   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         s1_valid_q <= 1'b0;
         s1_word_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_word_q  <= '0;
      end else begin
         s1_valid_q <= rd_ok;
         s1_word_q  <= rd_ok ? mem_q[bank_sel_q][rd_hcount_in] : '0;
         rd_valid_q <= s1_valid_q;
         rd_word_q  <= s1_word_q;
      end
   end

   assign rd_valid_out      = rd_valid_q;
   assign rd_lineHeight_out = rd_word_q[28:21];
   assign rd_wallType_out   = rd_word_q[20];
   assign rd_mapData_out    = rd_word_q[19:16];
   assign rd_wallX_out      = rd_word_q[15:0];
   assign bank_sel_out      = bank_sel_q;

`ifdef COLUMN_CHECK_EN
   logic [8:0] beat_cnt_q, beat_cnt_d;
   logic       err_q, err_d;

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      err_d      = err_q;
      if (accept) begin
         if (!wr_in_range) err_d = 1'b1;
         if (dda_out.tlast) begin
            // The tlast beat itself is the count+1-th beat of the frame.
            if (({1'b0, beat_cnt_q} + 10'd1) != WIDTH_L) err_d = 1'b1;
            beat_cnt_d = '0;
         end else begin
            beat_cnt_d = beat_cnt_q + 9'd1;
         end
      end
   end

   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         beat_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         err_q      <= err_d;
      end
   end

   assign column_err_out = err_q;
`else
   assign column_err_out = 1'b0;
`endif

endmodule
